// File: rtl/lava_rock_dropper.sv
// Falling-rock game core: steps one rock per rising edge of the game-speed wave,
// spawns it at an LFSR-chosen column, scores dodges and removes lives on hits.
// Latency: all outputs registered, one clk after the triggering edge/start; no backpressure.
//
// Ports:
//   clk, resetn   single clock, synchronous active-low reset
//   tick_in       game-speed square wave (synchronous to clk); one step per 0->1 edge
//   start         level; starts the game from IDLE or restarts it from OVER
//   player_x      player column, sampled when a rock lands
//   rock_x/rock_y current rock position, rock_valid = rock on screen
//   hit_pulse     one-cycle pulse when a landing rock hits the player
//   lives, score, game_over  game status
module lava_rock_dropper #(
    parameter int          SCREEN_W    = 160,
    parameter int          GROUND_Y    = 112,
    parameter int          STEP        = 4,
    parameter int          HIT_BAND    = 8,
    parameter int          START_LIVES = 3,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tick_in,
    input  logic        start,
    input  logic [7:0]  player_x,
    output logic [7:0]  rock_x,
    output logic [6:0]  rock_y,
    output logic        rock_valid,
    output logic        hit_pulse,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic        game_over
);

    localparam logic [8:0] SCREEN_W_L = SCREEN_W[8:0];
    localparam logic [7:0] GROUND_L   = GROUND_Y[7:0];
    localparam logic [7:0] STEP_L     = STEP[7:0];
    localparam logic [8:0] HIT_BAND_L = HIT_BAND[8:0];
    localparam logic [1:0] LIVES_L    = START_LIVES[1:0];
    localparam logic [8:0] SPAWN_OFS  = 9'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPAWN = 2'd1,
        ST_FALL  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  rock_x_q, rock_x_d;
    logic [6:0]  rock_y_q, rock_y_d;
    logic        rock_valid_q, rock_valid_d;
    logic        hit_pulse_q, hit_pulse_d;
    logic [1:0]  lives_q, lives_d;
    logic [15:0] score_q, score_d;
    logic        game_over_q, game_over_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        tick_q, tick_d;

    // ------------------------------------------------------------------
    // Shared combinational terms
    // ------------------------------------------------------------------
    logic        tick_rise;
    logic [7:0]  lfsr_next;
    logic [8:0]  spawn_sum;
    logic [8:0]  spawn_col;
    logic [7:0]  fall_sum;
    logic        lands;
    logic [8:0]  x_diff;
    logic [8:0]  x_dist;
    logic        is_hit;
    logic        land_evt;
    logic        last_life;

    assign tick_d    = tick_in;
    assign tick_rise = tick_in & ~tick_q;

    // x^8+x^6+x^5+x^4+1 Fibonacci form
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // 16..143 by construction; the fold only matters for a narrower screen
    assign spawn_sum = {2'b00, lfsr_q[6:0]} + SPAWN_OFS;
    assign spawn_col = (spawn_sum >= SCREEN_W_L) ? (spawn_sum - SCREEN_W_L) : spawn_sum;

    // 8-bit sum so a row near 127 can never wrap past the ground test
    assign fall_sum = {1'b0, rock_y_q} + STEP_L;
    assign lands    = (fall_sum >= GROUND_L);

    // 9-bit signed difference, then magnitude
    assign x_diff = {1'b0, rock_x_q} - {1'b0, player_x};
    assign x_dist = x_diff[8] ? (~x_diff + 9'd1) : x_diff;
    assign is_hit = (x_dist < HIT_BAND_L);

    assign land_evt  = (state_q == ST_FALL) && tick_rise && lands;
    assign last_life = (lives_q <= 2'd1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            rock_x_q     <= 8'd0;
            rock_y_q     <= 7'd0;
            rock_valid_q <= 1'b0;
            hit_pulse_q  <= 1'b0;
            lives_q      <= LIVES_L;
            score_q      <= 16'd0;
            game_over_q  <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            // Starts high so a wave already high at reset release is not an edge
            tick_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            rock_x_q     <= rock_x_d;
            rock_y_q     <= rock_y_d;
            rock_valid_q <= rock_valid_d;
            hit_pulse_q  <= hit_pulse_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            game_over_q  <= game_over_d;
            lfsr_q       <= lfsr_d;
            tick_q       <= tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SPAWN;
            ST_SPAWN: state_d = ST_FALL;
            ST_FALL: begin
                if (land_evt) begin
                    if (is_hit && last_life) state_d = ST_OVER;
                    else                     state_d = ST_SPAWN;
                end
            end
            ST_OVER:  if (start) state_d = ST_SPAWN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        rock_x_d     = rock_x_q;
        rock_y_d     = rock_y_q;
        rock_valid_d = rock_valid_q;
        hit_pulse_d  = 1'b0;
        lives_d      = lives_q;
        score_d      = score_q;
        game_over_d  = game_over_q;
        lfsr_d       = lfsr_q;

        case (state_q)
            ST_IDLE: begin
                rock_valid_d = 1'b0;
                if (start) begin
                    lives_d     = LIVES_L;
                    score_d     = 16'd0;
                    game_over_d = 1'b0;
                end
            end

            // Any tick edge coinciding with this cycle is intentionally lost
            ST_SPAWN: begin
                rock_x_d     = spawn_col[7:0];
                rock_y_d     = 7'd0;
                rock_valid_d = 1'b1;
                lfsr_d       = lfsr_next;
            end

            ST_FALL: begin
                if (tick_rise) begin
                    if (!lands) begin
                        rock_y_d = fall_sum[6:0];
                    end else begin
                        rock_y_d = GROUND_L[6:0];
                        if (is_hit) begin
                            hit_pulse_d = 1'b1;
                            if (last_life) begin
                                lives_d      = 2'd0;
                                game_over_d  = 1'b1;
                                rock_valid_d = 1'b0;
                            end else begin
                                lives_d = lives_q - 2'd1;
                            end
                        end else if (score_q != 16'hFFFF) begin
                            score_d = score_q + 16'd1;
                        end
                    end
                end
            end

            // Frozen until restart; the LFSR keeps its sequence across games
            ST_OVER: begin
                if (start) begin
                    lives_d     = LIVES_L;
                    score_d     = 16'd0;
                    game_over_d = 1'b0;
                end
            end

            default: ;
        endcase
    end

    assign rock_x     = rock_x_q;
    assign rock_y     = rock_y_q;
    assign rock_valid = rock_valid_q;
    assign hit_pulse  = hit_pulse_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_lava_rock_dropper.sv
module tb_lava_rock_dropper;

    logic        clk;
    logic        resetn;
    logic        tick_in;
    logic        start;
    logic [7:0]  player_x;
    logic [7:0]  rock_x;
    logic [6:0]  rock_y;
    logic        rock_valid;
    logic        hit_pulse;
    logic [1:0]  lives;
    logic [15:0] score;
    logic        game_over;

    int n_vec;
    int n_err;

    lava_rock_dropper dut (
        .clk        (clk),
        .resetn     (resetn),
        .tick_in    (tick_in),
        .start      (start),
        .player_x   (player_x),
        .rock_x     (rock_x),
        .rock_y     (rock_y),
        .rock_valid (rock_valid),
        .hit_pulse  (hit_pulse),
        .lives      (lives),
        .score      (score),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int hi, input int lo);
        tick_in = 1'b1;
        cyc(hi);
        tick_in = 1'b0;
        cyc(lo);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rock_x"},     32'(rock_x),     32'd0);
        chk({tag, "_rock_y"},     32'(rock_y),     32'd0);
        chk({tag, "_rock_valid"}, 32'(rock_valid), 32'd0);
        chk({tag, "_hit_pulse"},  32'(hit_pulse),  32'd0);
        chk({tag, "_lives"},      32'(lives),      32'd3);
        chk({tag, "_score"},      32'(score),      32'd0);
        chk({tag, "_game_over"},  32'(game_over),  32'd0);
    endtask

    // 27 steps of 4 rows with uneven high/low widths: rows 4..108
    task automatic fall27();
        for (int i = 0; i < 27; i++) begin
            tick(1 + (i % 3), 1 + ((i * 7) % 4));
            chk("fall_row", 32'(rock_y), 32'(4 * (i + 1)));
        end
    endtask

    // 28th edge lands the rock; the following cycle is SPAWN (or OVER)
    task automatic land(input logic [7:0] px, input logic exp_hit, input logic [1:0] exp_lives,
                        input logic [15:0] exp_score, input logic exp_go, input logic [7:0] exp_next_x);
        player_x = px;
        tick_in  = 1'b1;
        cyc(1);
        chk("land_hit_pulse", 32'(hit_pulse), 32'(exp_hit));
        chk("land_rock_y",    32'(rock_y),    32'd112);
        chk("land_lives",     32'(lives),     32'(exp_lives));
        chk("land_score",     32'(score),     32'(exp_score));
        chk("land_game_over", 32'(game_over), 32'(exp_go));
        tick_in = 1'b0;
        cyc(1);
        chk("post_hit_pulse", 32'(hit_pulse),  32'd0);
        chk("post_rock_x",    32'(rock_x),     32'(exp_next_x));
        chk("post_valid",     32'(rock_valid), 32'(!exp_go));
        if (!exp_go) chk("post_rock_y", 32'(rock_y), 32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        resetn   = 1'b0;
        start    = 1'b0;
        tick_in  = 1'b0;
        player_x = 8'd200;

        // Reset state
        cyc(2);
        chk_reset_vals("reset");
        resetn = 1'b1;
        cyc(3);
        chk("idle_valid", 32'(rock_valid), 32'd0);

        // Start: IDLE -> SPAWN, then the first rock appears at column 53
        start = 1'b1;
        cyc(1);
        chk("start_pre_spawn_valid", 32'(rock_valid), 32'd0);
        chk("start_lives",           32'(lives),      32'd3);
        start = 1'b0;
        cyc(1);
        chk("spawn1_x",     32'(rock_x),     32'd53);
        chk("spawn1_y",     32'(rock_y),     32'd0);
        chk("spawn1_valid", 32'(rock_valid), 32'd1);

        // No edges: position holds
        cyc(20);
        chk("hold_no_tick", 32'(rock_y), 32'd0);

        // Rock 1 (x=53) far from player: dodge, next column 90
        fall27();
        land(8'd200, 1'b0, 2'd3, 16'd1, 1'b0, 8'd90);

        // Rock 2 (x=90), distance exactly 8: still a miss, next column 37
        fall27();
        land(8'd98, 1'b0, 2'd3, 16'd2, 1'b0, 8'd37);

        // Rock 3 (x=37), player 7 to the right: hit, next column 58
        fall27();
        land(8'd44, 1'b1, 2'd2, 16'd2, 1'b0, 8'd58);

        // Rock 4 (x=58), player 7 to the left: hit, next column 100
        fall27();
        land(8'd51, 1'b1, 2'd1, 16'd2, 1'b0, 8'd100);

        // Rock 5 (x=100), dead-on: last life lost, game over
        fall27();
        land(8'd100, 1'b1, 2'd0, 16'd2, 1'b1, 8'd100);

        // OVER ignores ticks
        repeat (3) tick(2, 2);
        chk("over_lives",     32'(lives),      32'd0);
        chk("over_game_over", 32'(game_over),  32'd1);
        chk("over_valid",     32'(rock_valid), 32'd0);
        chk("over_score",     32'(score),      32'd2);
        chk("over_rock_x",    32'(rock_x),     32'd100);
        chk("over_rock_y",    32'(rock_y),     32'd112);
        chk("over_hit_pulse", 32'(hit_pulse),  32'd0);

        // Restart: status reloads, LFSR continues (column 57, not 53)
        start = 1'b1;
        cyc(1);
        chk("restart_lives",     32'(lives),     32'd3);
        chk("restart_score",     32'(score),     32'd0);
        chk("restart_game_over", 32'(game_over), 32'd0);
        start = 1'b0;
        cyc(1);
        chk("restart_x",     32'(rock_x),     32'd57);
        chk("restart_y",     32'(rock_y),     32'd0);
        chk("restart_valid", 32'(rock_valid), 32'd1);

        // Wave held high for 10k cycles counts as a single step
        tick_in = 1'b1;
        cyc(10000);
        chk("long_high_y", 32'(rock_y), 32'd4);
        tick_in = 1'b0;
        cyc(3);
        chk("long_high_after_low_y", 32'(rock_y), 32'd4);
        tick(1, 1);
        chk("second_step_y", 32'(rock_y), 32'd8);

        // Reset mid-FALL with start held: start is ignored during reset
        resetn = 1'b0;
        start  = 1'b1;
        cyc(1);
        chk_reset_vals("midfall_reset");
        resetn = 1'b1;
        start  = 1'b0;
        cyc(5);
        tick(1, 1);
        cyc(5);
        chk("no_spawn_valid", 32'(rock_valid), 32'd0);
        chk("no_spawn_x",     32'(rock_x),     32'd0);
        chk("no_spawn_y",     32'(rock_y),     32'd0);

        // Edge lands on the SPAWN cycle: dropped, rock stays at row 0
        start = 1'b1;
        cyc(1);
        start   = 1'b0;
        tick_in = 1'b1;
        cyc(1);
        chk("aligned_x",     32'(rock_x),     32'd53);
        chk("aligned_y",     32'(rock_y),     32'd0);
        chk("aligned_valid", 32'(rock_valid), 32'd1);
        cyc(3);
        chk("aligned_hold_y", 32'(rock_y), 32'd0);
        tick_in = 1'b0;
        cyc(1);
        tick(1, 1);
        chk("aligned_next_y", 32'(rock_y), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lava_rock_dropper.md
Name: lava_rock_dropper

Overview:
- Consumes the slow game-speed square wave from the game-speed divider and advances one falling lava rock per rising edge of that wave.
- Spawns rocks at pseudo-random columns, detects whether a rock landing on the ground row hits the player, and maintains lives, score and game-over.
- Sits between the speed divider (upstream) and the VGA draw/datapath logic (downstream), all in the single `clk` domain.

Parameters:
- SCREEN_W, 160, screen width in pixels; spawn columns must stay below it.
- GROUND_Y, 112, ground row; a rock lands when rock_y + STEP >= GROUND_Y.
- STEP, 4, pixels the rock falls per tick.
- HIT_BAND, 8, a hit occurs when |rock_x - player_x| < HIT_BAND.
- START_LIVES, 3, lives loaded on reset and on start.
- LFSR_SEED, 8'hA5, non-zero LFSR reset value.

Ports:
- clk  in  1  system clock (50 MHz), single clock domain.
- resetn  in  1  synchronous, active-low reset.
- tick_in  in  1  game-speed square wave from the speed divider, synchronous to clk.
- start  in  1  level; starts or restarts the game from IDLE or OVER.
- player_x  in  8  player column.
- rock_x  out  8  current rock column.
- rock_y  out  7  current rock row.
- rock_valid  out  1  rock is on screen.
- hit_pulse  out  1  one-cycle pulse on a hit.
- lives  out  2  remaining lives.
- score  out  16  rocks dodged, saturating.
- game_over  out  1  high in the OVER state.

Behaviour:
- Interface: one clock, `clk`. Reset `resetn` is synchronous and active-low. All outputs are registered.
- Reset values:
  - state=IDLE, rock_x=0, rock_y=0, rock_valid=0, hit_pulse=0.
  - lives=START_LIVES, score=0, game_over=0.
  - lfsr=LFSR_SEED, tick_q=1.
  - tick_q resets to 1 so a high tick_in at reset release is not counted as an edge.
- Edge detect:
  - tick_q <= tick_in every cycle.
  - tick_rise = tick_in & ~tick_q.
  - Exactly one step per 0->1 transition of tick_in, regardless of high/low duration.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances only in the SPAWN cycle.
- IDLE:
  - rock_valid=0.
  - start=1 -> lives<=START_LIVES, score<=0, game_over<=0, next state SPAWN.
- SPAWN (exactly one cycle):
  - rock_x <= {1'b0, lfsr[6:0]} + 16, range 16..143.
  - rock_y <= 0, rock_valid <= 1, lfsr <= next.
  - Next state FALL.
  - A tick_rise in this cycle is dropped.
- FALL, on tick_rise:
  - Compute rock_y + STEP in 8 bits; no wrap.
  - If the sum < GROUND_Y: rock_y += STEP.
  - Otherwise the rock lands: rock_y <= GROUND_Y, then collision is evaluated against the same-cycle player_x using 9-bit absolute difference.
  - Miss: score+1, saturating at 16'hFFFF; next state SPAWN.
  - Hit: hit_pulse=1 for the next cycle only; lives-1.
    - If lives was 1: lives<=0, game_over<=1, rock_valid<=0, next state OVER.
    - Otherwise: next state SPAWN.
  - No tick_rise: hold all state.
- Landing timing: with the defaults, a rock lands on the 28th tick_rise after SPAWN. rock_y reaches 108 after 27 ticks.
- OVER:
  - Outputs frozen; tick_rise ignored.
  - start=1 -> lives reload, score clear, game_over<=0, next state SPAWN.
  - The LFSR is not reseeded.
- start is ignored in SPAWN and FALL.
- resetn low in any state, including mid-FALL: all registers take reset values at the next clk edge; start is ignored while resetn is low.

Test Plan:
- Reset, then start=1 -> after 1 cycle state SPAWN; next cycle rock_x=53, rock_y=0, rock_valid=1; lfsr=8'h4A.
- player_x=200, 28 tick_in rising edges with varying high/low widths -> rock_y=108 after edge 27; after edge 28, score=1, hit_pulse never high; next rock_x=90.
- Collision boundary: rock_x=53, player_x=60 at landing -> hit_pulse one cycle, lives 3->2. Repeat with player_x=61 -> miss, score+1, lives unchanged.
- Three consecutive hits -> lives 2,1,0; game_over=1, rock_valid=0 after the third. Further ticks cause no change. start=1 -> lives=3, score=0, game_over=0, new spawn.
- Hold tick_in high for 10k cycles, then low -> rock_y advances only once. A tick_rise aligned with the SPAWN cycle -> rock_y stays 0.
- resetn=0 for one cycle mid-FALL with start=1 -> next cycle state IDLE, all outputs at reset values; no spawn until start is reasserted after resetn=1.
